minha_ram_param: RTL and testbench
==================================

# minha_ram_param

Parametrised successor to the fixed 64×16 RAM. Word width and depth are parameters, and asynchronous read plus single-port synchronous write are kept. A built-in clear engine fills every word with a programmable value after reset or on command, which gives the memory a deterministic power-up state. It sits in the memory subsystem next to the program counter and serves as the data/instruction store for the CPU datapath.

## Interface

**Parameters**
- `LARGURA_DADOS`, default 16: word width in bits.
- `LARGURA_END`, default 6: address width; depth is 2^LARGURA_END words.
- `VALOR_LIMPEZA`, default 0: LARGURA_DADOS-bit value written to every word by the clear engine.

**Ports**
- `clock_principal`  in  1: single clock; all state changes on its rising edge.
- `reset_principal`  in  1: reset, asynchronous, active-high.
- `dados_entrada`  in  LARGURA_DADOS: write data.
- `endereco_acesso`  in  LARGURA_END: read/write address.
- `controle_write`  in  1: write enable, sampled on the rising edge.
- `controle_limpar`  in  1: clear request, sampled on the rising edge.
- `dados_saida`  out  LARGURA_DADOS: read data (combinational from the array and the state).
- `ocupado`  out  1: high while the clear engine runs.
- `limpeza_concluida`  out  1: one-cycle pulse when a clear completes.

## Operation

**State machine:** two states, OCIOSO and LIMPANDO, plus a LARGURA_END-bit counter `contador`.

**Reset asserted (asynchronous)**
- State goes to LIMPANDO and `contador` to 0.
- `ocupado`=1, `limpeza_concluida`=0, `dados_saida`=0.
- Array contents are not reset directly; the clear engine initialises them.

**LIMPANDO, each rising edge**
- Write VALOR_LIMPEZA to mem[contador], then increment `contador`.
- On the edge that writes address 2^LARGURA_END−1: state goes to OCIOSO, `ocupado` goes to 0, `limpeza_concluida` goes to 1.
- User writes (`controle_write`) are ignored.
- `controle_limpar` is ignored; there is no restart.
- `dados_saida` is forced to 0 regardless of address.

**OCIOSO, each rising edge**
- `controle_limpar`=1: state goes to LIMPANDO and `contador` to 0. Any simultaneous `controle_write` is suppressed because clear has priority.
- Otherwise, `controle_write`=1: mem[endereco_acesso] takes `dados_entrada`.
- `limpeza_concluida` returns to 0 one edge after it was set.
- `dados_saida` = mem[endereco_acesso], combinational. It follows address changes with no clock, and write data appears after the writing edge.

**Other rules**
- `ocupado` is registered and equals (state == LIMPANDO).
- Counter wrap at 2^LARGURA_END−1 is the terminating condition; `contador` is don't-care in OCIOSO.
- Reset asserted mid-clear or mid-operation restarts the clear from address 0. Words already written are overwritten again.

## Timing

- A clear takes exactly 2^LARGURA_END rising edges. After reset release, edges 1..2^N write addresses 0..2^N−1, and `ocupado` falls after edge 2^N.
- `limpeza_concluida` is high from edge 2^N to edge 2^N+1 (one cycle).
- A commanded clear: the edge sampling `controle_limpar` only starts it (no array write). Clear writes follow on the next 2^N edges, so `ocupado` is high for 2^N cycles.
- Write latency: write on edge k; `dados_saida` at the same address shows the new value after edge k and the old value before it.
- Read latency: zero cycles (combinational) from `endereco_acesso` to `dados_saida` while OCIOSO.
- The first user write is accepted on edge 2^N+1 after reset release.

## Test plan

Defaults apply (16-bit, 64 words, VALOR_LIMPEZA=0) unless stated.

1. **Power-up clear.** Pulse reset, then release. `ocupado`=1 for 64 cycles and `dados_saida`=0 throughout. `limpeza_concluida` pulses exactly once at cycle 64. Reading addresses 0, 31 and 63 then returns 0x0000.
2. **Write/read sweep.** Write 0xAAAA→0, 0x5555→1, 0xF0F0→2, 0xCCCC→8, 0x3333→16, 0xA5A5→32, 0x5A5A→63. Reading back returns each value, and unwritten address 5 reads 0x0000.
3. **Write-enable gating.** Hold `controle_write`=0 with `dados_entrada`=0xFFFF at address 0, so address 0 keeps 0xAAAA. Then pulse `controle_write`=1 for one edge; address 0 reads 0xFFFF.
4. **Commanded clear priority.** In OCIOSO, assert `controle_limpar`=1 and `controle_write`=1 with 0x1234 at address 7 on the same edge. Address 7 is not written. `ocupado`=1 for 64 cycles, and all addresses read 0 afterwards. Writes attempted during the clear are lost.
5. **Reset mid-clear.** Instance with VALOR_LIMPEZA=0xBEEF: assert reset at clear cycle 20, release, and count again. `ocupado` lasts a full 64 cycles from the release, `limpeza_concluida` pulses once, and all words read 0xBEEF.
6. **Parameter sweep.** LARGURA_DADOS=8, LARGURA_END=3: clear lasts 8 cycles. Write 0x81 to address 7; it reads back 0x81, and address 0 reads VALOR_LIMPEZA.

Source files
------------

// File: rtl/minha_ram_param.sv
// Parametrised RAM: asynchronous read, single-port synchronous write, and a
// built-in clear engine that fills every word with VALOR_LIMPEZA.
//
// state    | meaning
// OCIOSO   | normal operation: user reads and writes
// LIMPANDO | clear engine writes VALOR_LIMPEZA to mem[contador]; output forced to 0
module minha_ram_param #(
  parameter int                       LARGURA_DADOS = 16,
  parameter int                       LARGURA_END   = 6,
  parameter logic [LARGURA_DADOS-1:0] VALOR_LIMPEZA = '0
) (
  input  logic                     clock_principal,
  input  logic                     reset_principal,
  input  logic [LARGURA_DADOS-1:0] dados_entrada,
  input  logic [LARGURA_END-1:0]   endereco_acesso,
  input  logic                     controle_write,
  input  logic                     controle_limpar,
  output logic [LARGURA_DADOS-1:0] dados_saida,
  output logic                     ocupado,
  output logic                     limpeza_concluida
);

  localparam int PROFUNDIDADE = 1 << LARGURA_END;

  typedef enum logic {OCIOSO, LIMPANDO} estado_t;

  estado_t                  estado;
  logic [LARGURA_END-1:0]   contador;
  logic [LARGURA_DADOS-1:0] mem [PROFUNDIDADE];

  always_ff @(posedge clock_principal or posedge reset_principal) begin
    if (reset_principal) begin
      estado            <= LIMPANDO;
      contador          <= '0;
      ocupado           <= 1'b1;
      limpeza_concluida <= 1'b0;
    end else begin
      limpeza_concluida <= 1'b0;
      case (estado)
        LIMPANDO: begin
          contador <= contador + 1'b1;
          // Terminal count: the edge writing the last word ends the clear.
          if (contador == '1) begin
            estado            <= OCIOSO;
            ocupado           <= 1'b0;
            limpeza_concluida <= 1'b1;
          end
        end
        default: begin
          if (controle_limpar) begin
            estado   <= LIMPANDO;
            contador <= '0;
            ocupado  <= 1'b1;
          end
        end
      endcase
    end
  end

  // The array has no reset; while reset is held this only rewrites word 0,
  // which the restarted clear overwrites anyway.
  always_ff @(posedge clock_principal) begin
    if (estado == LIMPANDO)
      mem[contador] <= VALOR_LIMPEZA;
    else if (controle_write && !controle_limpar)
      mem[endereco_acesso] <= dados_entrada;
  end

  assign dados_saida = (estado == OCIOSO) ? mem[endereco_acesso] : '0;

endmodule

// File: tb/tb_minha_ram_param.sv
// Bench for minha_ram_param: three instances (default, VALOR_LIMPEZA=0xBEEF,
// 8-bit x 8 words) checked every half cycle against a behavioural model.
module tb_minha_ram_param;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        we  [3];
  logic        lim [3];
  logic [15:0] din [3];
  logic [5:0]  addr [3];
  logic [15:0] dout0, dout1;
  logic [7:0]  dout2;
  logic        busy_w [3];
  logic        done_w [3];

  always #5 clk = ~clk;

  minha_ram_param u_dut0 (
    .clock_principal(clk), .reset_principal(rst[0]), .dados_entrada(din[0]),
    .endereco_acesso(addr[0]), .controle_write(we[0]), .controle_limpar(lim[0]),
    .dados_saida(dout0), .ocupado(busy_w[0]), .limpeza_concluida(done_w[0]));

  minha_ram_param #(.VALOR_LIMPEZA(16'hBEEF)) u_dut1 (
    .clock_principal(clk), .reset_principal(rst[1]), .dados_entrada(din[1]),
    .endereco_acesso(addr[1]), .controle_write(we[1]), .controle_limpar(lim[1]),
    .dados_saida(dout1), .ocupado(busy_w[1]), .limpeza_concluida(done_w[1]));

  minha_ram_param #(.LARGURA_DADOS(8), .LARGURA_END(3)) u_dut2 (
    .clock_principal(clk), .reset_principal(rst[2]), .dados_entrada(din[2][7:0]),
    .endereco_acesso(addr[2][2:0]), .controle_write(we[2]), .controle_limpar(lim[2]),
    .dados_saida(dout2), .ocupado(busy_w[2]), .limpeza_concluida(done_w[2]));

  // Behavioural model: clear edges remaining, completion pulse, memory image.
  int          depth [3] = '{64, 64, 8};
  logic [15:0] cv    [3] = '{16'h0000, 16'hBEEF, 16'h0000};
  logic [15:0] mask  [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
  int          bl    [3];
  logic        md    [3];
  logic [15:0] mm    [3][64];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int bc [3];
  int pc [3];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic mdl_reset(input int i);
    bl[i] = depth[i];
    md[i] = 1'b0;
  endtask

  function automatic logic [15:0] dout_of(input int i);
    case (i)
      0:       return dout0;
      1:       return dout1;
      default: return {8'h00, dout2};
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) mdl_reset(i);
      else begin
        md[i] = 1'b0;
        if (bl[i] > 0) begin
          mm[i][depth[i] - bl[i]] = cv[i];
          bl[i]--;
          if (bl[i] == 0) md[i] = 1'b1;
        end else if (lim[i]) bl[i] = depth[i];
        else if (we[i]) mm[i][int'(addr[i]) % depth[i]] = din[i] & mask[i];
      end
    end
  end

  task automatic cmp_all();
    logic        eb;
    logic [15:0] ed;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) mdl_reset(i);
      eb = (bl[i] > 0);
      ed = eb ? 16'h0000 : mm[i][int'(addr[i]) % depth[i]];
      chk($sformatf("dut%0d ocupado", i), {15'd0, busy_w[i]}, {15'd0, eb});
      chk($sformatf("dut%0d concluida", i), {15'd0, done_w[i]}, {15'd0, md[i]});
      chk($sformatf("dut%0d dados_saida", i), dout_of(i), ed);
    end
  endtask

  // Compare after each edge and again after each input change.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) cmp_all();
      @(negedge clk); #2;
      if (chk_en) cmp_all();
    end
  end

  // Busy-cycle and completion-pulse counters, one sample per cycle.
  initial begin
    forever begin
      @(negedge clk); #2;
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bc[i]++;
        if (done_w[i]) pc[i]++;
      end
    end
  end

  task automatic wr(input int i, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    addr[i] = a; din[i] = d; we[i] = 1'b1;
    @(negedge clk);
    we[i] = 1'b0;
  endtask

  task automatic rd(input int i, input logic [5:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    addr[i] = a;
    #2 chk(nm, dout_of(i), exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; we[i] = 1'b0; lim[i] = 1'b0; din[i] = '0; addr[i] = '0;
      bc[i] = 0; pc[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    chk_en = 1'b1;

    // Power-up clear on all instances.
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; bc[i] = 0; pc[i] = 0; end
    repeat (80) @(negedge clk);
    #3;
    chk("pwr busy cycles dut0", 16'(bc[0]), 16'd64);
    chk("pwr pulses dut0",      16'(pc[0]), 16'd1);
    chk("pwr busy cycles dut1", 16'(bc[1]), 16'd64);
    chk("pwr pulses dut1",      16'(pc[1]), 16'd1);
    chk("pwr busy cycles dut2", 16'(bc[2]), 16'd8);
    chk("pwr pulses dut2",      16'(pc[2]), 16'd1);
    rd(0, 6'd0,  16'h0000, "pwr rd 0");
    rd(0, 6'd31, 16'h0000, "pwr rd 31");
    rd(0, 6'd63, 16'h0000, "pwr rd 63");

    // Write/read sweep.
    wr(0, 6'd0,  16'hAAAA);
    wr(0, 6'd1,  16'h5555);
    wr(0, 6'd2,  16'hF0F0);
    wr(0, 6'd8,  16'hCCCC);
    wr(0, 6'd16, 16'h3333);
    wr(0, 6'd32, 16'hA5A5);
    wr(0, 6'd63, 16'h5A5A);
    rd(0, 6'd0,  16'hAAAA, "sweep rd 0");
    rd(0, 6'd1,  16'h5555, "sweep rd 1");
    rd(0, 6'd2,  16'hF0F0, "sweep rd 2");
    rd(0, 6'd8,  16'hCCCC, "sweep rd 8");
    rd(0, 6'd16, 16'h3333, "sweep rd 16");
    rd(0, 6'd32, 16'hA5A5, "sweep rd 32");
    rd(0, 6'd63, 16'h5A5A, "sweep rd 63");
    rd(0, 6'd5,  16'h0000, "sweep rd 5");

    // Write-enable gating.
    @(negedge clk);
    addr[0] = 6'd0; din[0] = 16'hFFFF; we[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk("gate hold rd 0", dout0, 16'hAAAA);
    wr(0, 6'd0, 16'hFFFF);
    rd(0, 6'd0, 16'hFFFF, "gate pulse rd 0");

    // Parameter sweep instance.
    wr(2, 6'd7, 16'h0081);
    rd(2, 6'd7, 16'h0081, "small rd 7");
    rd(2, 6'd0, 16'h0000, "small rd 0");

    // Commanded clear with a simultaneous write, then writes during the clear.
    @(negedge clk);
    addr[0] = 6'd7; din[0] = 16'h1234; we[0] = 1'b1; lim[0] = 1'b1;
    bc[0] = 0; pc[0] = 0;
    @(negedge clk);
    lim[0] = 1'b0; addr[0] = 6'd9; din[0] = 16'hDEAD;
    repeat (60) @(negedge clk);
    we[0] = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    chk("cmd busy cycles", 16'(bc[0]), 16'd64);
    chk("cmd pulses",      16'(pc[0]), 16'd1);
    for (int a = 0; a < 64; a++) rd(0, 6'(a), 16'h0000, $sformatf("cmd rd %0d", a));

    // Reset in the middle of a clear.
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (20) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0; bc[1] = 0; pc[1] = 0;
    repeat (75) @(negedge clk);
    #3;
    chk("midrst busy cycles", 16'(bc[1]), 16'd64);
    chk("midrst pulses",      16'(pc[1]), 16'd1);
    for (int a = 0; a < 64; a++) rd(1, 6'(a), 16'hBEEF, $sformatf("midrst rd %0d", a));

    // Randomised traffic, checked by the compare process.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        we[i]   = 1'($urandom_range(0, 1));
        lim[i]  = ($urandom_range(0, 59) == 0);
        addr[i] = 6'($urandom_range(0, depth[i] - 1));
        din[i]  = 16'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin we[i] = 1'b0; lim[i] = 1'b0; end
    repeat (70) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
